// File: rtl/vga_sprite_compositor_if.sv
// Pixel, sprite, ROM and fade signals between the VGA timing/ROM side and the
// sprite compositor. The master drives the pixel stream and ROM data; the slave composites.
interface vga_sprite_compositor_if #(
    parameter int NUM_SPRITES = 8,
    parameter int SPRITE_W    = 30,
    parameter int SPRITE_H    = 30
);
    localparam int AW = $clog2(SPRITE_W * SPRITE_H);

    logic [9:0]               pix_x;
    logic [8:0]               pix_y;
    logic                     pix_valid;
    logic                     frame_start;
    logic [NUM_SPRITES-1:0]   spr_en;
    logic [NUM_SPRITES*10-1:0] spr_x;
    logic [NUM_SPRITES*9-1:0] spr_y;
    logic [NUM_SPRITES*AW-1:0] spr_rom_addr;
    logic [NUM_SPRITES*12-1:0] spr_rom_data;
    logic [18:0]              bg_rom_addr;
    logic [11:0]              bg_rom_data;
    logic [1:0]               fade_req;
    logic                     fade_busy;
    logic [11:0]              rgb;
    logic                     rgb_valid;

    modport master (
        output pix_x, pix_y, pix_valid, frame_start, spr_en, spr_x, spr_y,
               spr_rom_data, bg_rom_data, fade_req,
        input  spr_rom_addr, bg_rom_addr, fade_busy, rgb, rgb_valid
    );

    modport slave (
        input  pix_x, pix_y, pix_valid, frame_start, spr_en, spr_x, spr_y,
               spr_rom_data, bg_rom_data, fade_req,
        output spr_rom_addr, bg_rom_addr, fade_busy, rgb, rgb_valid
    );
endinterface

// File: rtl/vga_sprite_compositor.sv
// Sprite-over-background pixel compositor with colour-key transparency, index
// priority, ROM-latency alignment and a frame-synchronous fade engine; BGR output.
module vga_sprite_compositor #(
    parameter int          NUM_SPRITES     = 8,
    parameter int          SPRITE_W        = 30,
    parameter int          SPRITE_H        = 30,
    parameter int          SCREEN_W        = 640,
    parameter int          ROM_LAT         = 1,
    parameter logic [11:0] KEY_COLOR       = 12'hF0F,
    parameter int          FRAMES_PER_STEP = 2
) (
    input logic                    clk,
    input logic                    rst,
    vga_sprite_compositor_if.slave bus
);
    localparam int AW = $clog2(SPRITE_W * SPRITE_H);
    localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {
        ST_ON       = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_OFF      = 2'd2,
        ST_FADE_IN  = 2'd3
    } fade_state_t;

    // Scales one 4-bit channel by level/16; level 16 is identity, 0 is black.
    function automatic logic [3:0] scale_chan(input logic [3:0] c, input logic [4:0] lvl);
        return 4'((9'(c) * 9'(lvl)) >> 4);
    endfunction

    logic [10:0]               px_s;
    logic [9:0]                py_s;
    logic [NUM_SPRITES-1:0]    hit_s;
    logic [NUM_SPRITES*AW-1:0] spr_addr_s;
    logic [NUM_SPRITES-1:0]    hit_dly_r [ROM_LAT];
    logic                      valid_dly_r [ROM_LAT];
    logic [11:0]               sel_s;
    logic [11:0]               rgb_r;
    logic                      rgb_valid_r;
    fade_state_t               state_r;
    logic [4:0]                level_r;
    logic [CW-1:0]             frame_cnt_r;
    logic                      fade_busy_r;

    // Widened by one bit so spr_x+SPRITE_W / spr_y+SPRITE_H never wrap near the edges.
    assign px_s = {1'b0, bus.pix_x};
    assign py_s = {1'b0, bus.pix_y};

    // Stage A: per-sprite hit test and sprite-local ROM address.
    always_comb begin
        hit_s      = '0;
        spr_addr_s = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            hit_s[i] = bus.spr_en[i]
                && (px_s >= {1'b0, bus.spr_x[i*10 +: 10]})
                && (px_s <  ({1'b0, bus.spr_x[i*10 +: 10]} + 11'(SPRITE_W)))
                && (py_s >= {1'b0, bus.spr_y[i*9 +: 9]})
                && (py_s <  ({1'b0, bus.spr_y[i*9 +: 9]} + 10'(SPRITE_H)));
            spr_addr_s[i*AW +: AW] = hit_s[i]
                ? (AW'(px_s - {1'b0, bus.spr_x[i*10 +: 10]})
                   + AW'(py_s - {1'b0, bus.spr_y[i*9 +: 9]}) * AW'(SPRITE_W))
                : {AW{1'b0}};
        end
    end

    assign bus.spr_rom_addr = spr_addr_s;
    assign bus.bg_rom_addr  = 19'(bus.pix_x) + 19'(bus.pix_y) * 19'(SCREEN_W);

    // Delay line holding hit vector and pixel qualifier until ROM data returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ROM_LAT; k++) begin
                hit_dly_r[k]   <= '0;
                valid_dly_r[k] <= 1'b0;
            end
        end else begin
            hit_dly_r[0]   <= hit_s;
            valid_dly_r[0] <= bus.pix_valid;
            for (int k = 1; k < ROM_LAT; k++) begin
                hit_dly_r[k]   <= hit_dly_r[k-1];
                valid_dly_r[k] <= valid_dly_r[k-1];
            end
        end
    end

    // Stage B: walking down from the highest index leaves the lowest opaque hit.
    always_comb begin
        sel_s = bus.bg_rom_data;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            sel_s = (hit_dly_r[ROM_LAT-1][i] && (bus.spr_rom_data[i*12 +: 12] != KEY_COLOR))
                  ? bus.spr_rom_data[i*12 +: 12] : sel_s;
        end
    end

    // Output register: fade scaling plus RGB to BGR swap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_r       <= 12'h000;
            rgb_valid_r <= 1'b0;
        end else begin
            rgb_r       <= {scale_chan(sel_s[3:0], level_r),
                            scale_chan(sel_s[7:4], level_r),
                            scale_chan(sel_s[11:8], level_r)};
            rgb_valid_r <= valid_dly_r[ROM_LAT-1];
        end
    end

    // Fade FSM: level only moves on frame_start so each frame uses one level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_ON;
            level_r     <= 5'd16;
            frame_cnt_r <= '0;
            fade_busy_r <= 1'b0;
        end else begin
            case (state_r)
                ST_ON: begin
                    if (bus.fade_req == 2'b01) begin
                        state_r     <= ST_FADE_OUT;
                        frame_cnt_r <= '0;
                        fade_busy_r <= 1'b1;
                    end
                end
                ST_OFF: begin
                    if (bus.fade_req == 2'b10) begin
                        state_r     <= ST_FADE_IN;
                        frame_cnt_r <= '0;
                        fade_busy_r <= 1'b1;
                    end
                end
                ST_FADE_OUT: begin
                    if (bus.frame_start) begin
                        if (frame_cnt_r == CNT_LAST) begin
                            frame_cnt_r <= '0;
                            level_r     <= level_r - 5'd1;
                            if (level_r == 5'd1) begin
                                state_r     <= ST_OFF;
                                fade_busy_r <= 1'b0;
                            end
                        end else begin
                            frame_cnt_r <= frame_cnt_r + CW'(1);
                        end
                    end
                end
                ST_FADE_IN: begin
                    if (bus.frame_start) begin
                        if (frame_cnt_r == CNT_LAST) begin
                            frame_cnt_r <= '0;
                            level_r     <= level_r + 5'd1;
                            if (level_r == 5'd15) begin
                                state_r     <= ST_ON;
                                fade_busy_r <= 1'b0;
                            end
                        end else begin
                            frame_cnt_r <= frame_cnt_r + CW'(1);
                        end
                    end
                end
                default: begin
                    state_r     <= ST_ON;
                    level_r     <= 5'd16;
                    frame_cnt_r <= '0;
                    fade_busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rgb       = rgb_r;
    assign bus.rgb_valid = rgb_valid_r;
    assign bus.fade_busy = fade_busy_r;
endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Self-checking bench for vga_sprite_compositor: synchronous ROM models, a
// screen-level reference model for compositing and fade, randomized pixel streams.
module tb_vga_sprite_compositor;
    localparam int          NS  = 8;
    localparam int          SW  = 30;
    localparam int          SH  = 30;
    localparam int          AW  = $clog2(SW * SH);
    localparam logic [11:0] KEY = 12'hF0F;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [11:0] bg_const;
    bit          use_pat;
    logic [11:0] spr_const [NS];
    int          sx [NS];
    int          sy [NS];
    bit          en [NS];

    typedef struct {bit v; logic [11:0] c;} exp_t;
    exp_t exp_q[$];

    vga_sprite_compositor_if #(.NUM_SPRITES(NS), .SPRITE_W(SW), .SPRITE_H(SH)) vif ();

    vga_sprite_compositor #(
        .NUM_SPRITES(NS), .SPRITE_W(SW), .SPRITE_H(SH), .SCREEN_W(640),
        .ROM_LAT(1), .KEY_COLOR(KEY), .FRAMES_PER_STEP(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(vif.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] bg_pat(input int a);
        return 12'(a * 97 + 5);
    endfunction

    function automatic logic [11:0] spr_pat(input int i, input int a);
        if (((a + i * 3) % 7) == 0) return KEY;
        return 12'(a * 53 + i * 311 + 1);
    endfunction

    // One-cycle synchronous ROMs
    always @(posedge clk) begin
        vif.bg_rom_data <= use_pat ? bg_pat(int'(vif.bg_rom_addr)) : bg_const;
        for (int i = 0; i < NS; i++)
            vif.spr_rom_data[i*12 +: 12] <= use_pat ? spr_pat(i, int'(vif.spr_rom_addr[i*AW +: AW]))
                                                    : spr_const[i];
    end

    function automatic int model_addr(input int i, input int x, input int y);
        if (en[i] && x >= sx[i] && x < sx[i] + SW && y >= sy[i] && y < sy[i] + SH)
            return (x - sx[i]) + (y - sy[i]) * SW;
        return -1;
    endfunction

    function automatic logic [11:0] model_pixel(input int x, input int y);
        logic [11:0] c;
        logic [11:0] d;
        int a;
        c = use_pat ? bg_pat(x + y * 640) : bg_const;
        for (int i = NS - 1; i >= 0; i--) begin
            a = model_addr(i, x, y);
            if (a >= 0) begin
                d = use_pat ? spr_pat(i, a) : spr_const[i];
                if (d != KEY) c = d;
            end
        end
        return c;
    endfunction

    function automatic logic [11:0] fade_bgr(input logic [11:0] c, input int lvl);
        int r, g, b;
        r = int'(c[11:8]) * lvl / 16;
        g = int'(c[7:4]) * lvl / 16;
        b = int'(c[3:0]) * lvl / 16;
        return {4'(b), 4'(g), 4'(r)};
    endfunction

    task automatic apply_cfg();
        for (int i = 0; i < NS; i++) begin
            vif.spr_en[i]          = en[i];
            vif.spr_x[i*10 +: 10]  = 10'(sx[i]);
            vif.spr_y[i*9 +: 9]    = 9'(sy[i]);
        end
    endtask

    task automatic clear_sprites();
        for (int i = 0; i < NS; i++) begin
            en[i] = 1'b0; sx[i] = 0; sy[i] = 0; spr_const[i] = 12'h000;
        end
        apply_cfg();
    endtask

    task automatic sample(input int x, input int y, output logic [11:0] o_rgb, output logic o_v);
        vif.pix_x = 10'(x); vif.pix_y = 9'(y); vif.pix_valid = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        o_rgb = vif.rgb; o_v = vif.rgb_valid;
        vif.pix_valid = 1'b0;
    endtask

    task automatic pulse_frame(input logic [1:0] req);
        vif.frame_start = 1'b1; vif.fade_req = req; vif.pix_valid = 1'b0;
        @(posedge clk); #1;
        vif.frame_start = 1'b0; vif.fade_req = 2'b00;
    endtask

    task automatic test_reset();
        logic [11:0] o; logic v;
        rst = 1'b1; use_pat = 1'b0; bg_const = 12'h000;
        vif.pix_x = 10'd0; vif.pix_y = 9'd0; vif.pix_valid = 1'b0;
        vif.frame_start = 1'b0; vif.fade_req = 2'b00;
        clear_sprites();
        repeat (3) @(posedge clk); #1;
        checks++; if (vif.rgb !== 12'h000) begin failures++; $display("FAIL reset_rgb got %h exp 000", vif.rgb); end
        checks++; if (vif.rgb_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", vif.rgb_valid); end
        checks++; if (vif.fade_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", vif.fade_busy); end
        rst = 1'b0; bg_const = 12'h123;
        vif.pix_x = 10'd639; vif.pix_y = 9'd479; #1;
        checks++; if (vif.bg_rom_addr !== 19'd307199) begin failures++; $display("FAIL bg_addr_corner got %0d exp 307199", vif.bg_rom_addr); end
        vif.pix_x = 10'd0; vif.pix_y = 9'd0; #1;
        checks++; if (vif.bg_rom_addr !== 19'd0) begin failures++; $display("FAIL bg_addr_origin got %0d exp 0", vif.bg_rom_addr); end
        sample(0, 0, o, v);
        checks++; if (o !== 12'h321) begin failures++; $display("FAIL bg_pass_rgb got %h exp 321", o); end
        checks++; if (v !== 1'b1) begin failures++; $display("FAIL bg_pass_valid got %b exp 1", v); end
        @(posedge clk); @(posedge clk); #1;
        checks++; if (vif.rgb_valid !== 1'b0) begin failures++; $display("FAIL invalid_slot got %b exp 0", vif.rgb_valid); end
    endtask

    task automatic test_priority();
        logic [11:0] o; logic v;
        clear_sprites();
        en[0] = 1'b1; sx[0] = 100; sy[0] = 50; spr_const[0] = 12'h0F0;
        en[3] = 1'b1; sx[3] = 100; sy[3] = 50; spr_const[3] = 12'hF00;
        apply_cfg(); bg_const = 12'h123;
        vif.pix_x = 10'd105; vif.pix_y = 9'd52; #1;
        checks++; if (vif.spr_rom_addr[0 +: AW] !== AW'(65)) begin failures++; $display("FAIL spr0_addr got %0d exp 65", vif.spr_rom_addr[0 +: AW]); end
        checks++; if (vif.spr_rom_addr[3*AW +: AW] !== AW'(65)) begin failures++; $display("FAIL spr3_addr got %0d exp 65", vif.spr_rom_addr[3*AW +: AW]); end
        checks++; if (vif.spr_rom_addr[1*AW +: AW] !== AW'(0)) begin failures++; $display("FAIL spr1_addr_nohit got %0d exp 0", vif.spr_rom_addr[1*AW +: AW]); end
        sample(105, 52, o, v);
        checks++; if (o !== 12'h0F0) begin failures++; $display("FAIL prio_spr0 got %h exp 0f0", o); end
        spr_const[0] = KEY;
        sample(105, 52, o, v);
        checks++; if (o !== 12'h00F) begin failures++; $display("FAIL key_fall_spr3 got %h exp 00f", o); end
        spr_const[3] = KEY;
        sample(105, 52, o, v);
        checks++; if (o !== 12'h321) begin failures++; $display("FAIL key_fall_bg got %h exp 321", o); end
    endtask

    task automatic test_edges();
        logic [11:0] o; logic v;
        clear_sprites();
        en[0] = 1'b1; sx[0] = 620; sy[0] = 100; spr_const[0] = 12'h0A5;
        apply_cfg(); bg_const = 12'h123;
        vif.pix_x = 10'd639; vif.pix_y = 9'd110; #1;
        checks++; if (vif.spr_rom_addr[0 +: AW] !== AW'(319)) begin failures++; $display("FAIL right_edge_addr got %0d exp 319", vif.spr_rom_addr[0 +: AW]); end
        sample(639, 110, o, v);
        checks++; if (o !== 12'h5A0) begin failures++; $display("FAIL right_edge_rgb got %h exp 5a0", o); end
        vif.pix_x = 10'd619; vif.pix_y = 9'd110; #1;
        checks++; if (vif.spr_rom_addr[0 +: AW] !== AW'(0)) begin failures++; $display("FAIL left_miss_addr got %0d exp 0", vif.spr_rom_addr[0 +: AW]); end
        sample(619, 110, o, v);
        checks++; if (o !== 12'h321) begin failures++; $display("FAIL left_miss_rgb got %h exp 321", o); end
        vif.pix_x = 10'd620; vif.pix_y = 9'd129; #1;
        checks++; if (vif.spr_rom_addr[0 +: AW] !== AW'(870)) begin failures++; $display("FAIL bottom_row_addr got %0d exp 870", vif.spr_rom_addr[0 +: AW]); end
        sample(620, 130, o, v);
        checks++; if (o !== 12'h321) begin failures++; $display("FAIL below_miss_rgb got %h exp 321", o); end
    endtask

    task automatic test_random();
        exp_t e;
        int x, y, k, a;
        bit v;
        clear_sprites();
        use_pat = 1'b1;
        for (int i = 0; i < NS - 1; i++) begin
            en[i] = ($urandom_range(0, 3) != 0);
            sx[i] = $urandom_range(0, 200);
            sy[i] = $urandom_range(0, 150);
        end
        en[NS-1] = 1'b1; sx[NS-1] = 1000; sy[NS-1] = 490;
        apply_cfg();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                x = $urandom_range(995, 1023); y = $urandom_range(485, 511);
            end else begin
                x = $urandom_range(0, 240); y = $urandom_range(0, 190);
            end
            v = ($urandom_range(0, 4) != 0);
            vif.pix_x = 10'(x); vif.pix_y = 9'(y); vif.pix_valid = v;
            #1;
            k = $urandom_range(0, NS - 1);
            a = model_addr(k, x, y);
            if (a < 0) a = 0;
            checks++; if (vif.spr_rom_addr[k*AW +: AW] !== AW'(a)) begin failures++; $display("FAIL rand_spr_addr s%0d (%0d,%0d) got %0d exp %0d", k, x, y, vif.spr_rom_addr[k*AW +: AW], a); end
            checks++; if (vif.bg_rom_addr !== 19'(x + y * 640)) begin failures++; $display("FAIL rand_bg_addr (%0d,%0d) got %0d exp %0d", x, y, vif.bg_rom_addr, x + y * 640); end
            exp_q.push_back('{v, fade_bgr(model_pixel(x, y), 16)});
            @(posedge clk); #1;
            if (exp_q.size() == 2) begin
                e = exp_q.pop_front();
                checks++; if (vif.rgb_valid !== e.v) begin failures++; $display("FAIL rand_valid n%0d got %b exp %b", n, vif.rgb_valid, e.v); end
                if (e.v) begin
                    checks++; if (vif.rgb !== e.c) begin failures++; $display("FAIL rand_rgb n%0d got %h exp %h", n, vif.rgb, e.c); end
                end
            end
        end
        vif.pix_valid = 1'b0;
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++; if (vif.rgb_valid !== e.v) begin failures++; $display("FAIL rand_last_valid got %b exp %b", vif.rgb_valid, e.v); end
        if (e.v) begin
            checks++; if (vif.rgb !== e.c) begin failures++; $display("FAIL rand_last_rgb got %h exp %h", vif.rgb, e.c); end
        end
        use_pat = 1'b0;
    endtask

    task automatic test_fade_out();
        logic [11:0] o; logic v;
        int lvl;
        clear_sprites(); bg_const = 12'hFFF;
        vif.fade_req = 2'b01; @(posedge clk); #1; vif.fade_req = 2'b00;
        checks++; if (vif.fade_busy !== 1'b1) begin failures++; $display("FAIL fade_out_busy_rise got %b exp 1", vif.fade_busy); end
        for (int p = 1; p <= 32; p++) begin
            pulse_frame(2'b00);
            lvl = 16 - p / 2;
            sample(320, 240, o, v);
            checks++; if (o !== fade_bgr(12'hFFF, lvl)) begin failures++; $display("FAIL fade_out_rgb pulse %0d got %h exp %h", p, o, fade_bgr(12'hFFF, lvl)); end
            checks++; if (vif.fade_busy !== (p < 32)) begin failures++; $display("FAIL fade_out_busy pulse %0d got %b exp %b", p, vif.fade_busy, (p < 32)); end
        end
        vif.fade_req = 2'b01; @(posedge clk); #1; vif.fade_req = 2'b00;
        pulse_frame(2'b00); pulse_frame(2'b00);
        sample(320, 240, o, v);
        checks++; if (vif.fade_busy !== 1'b0) begin failures++; $display("FAIL off_ignore_busy got %b exp 0", vif.fade_busy); end
        checks++; if (o !== 12'h000) begin failures++; $display("FAIL off_ignore_rgb got %h exp 000", o); end
    endtask

    task automatic test_fade_in_reset();
        logic [11:0] o; logic v;
        int lvl;
        pulse_frame(2'b10);
        checks++; if (vif.fade_busy !== 1'b1) begin failures++; $display("FAIL fade_in_busy_rise got %b exp 1", vif.fade_busy); end
        for (int p = 1; p <= 16; p++) begin
            pulse_frame((p == 5) ? 2'b01 : 2'b00);
            lvl = p / 2;
            sample(10, 10, o, v);
            checks++; if (o !== fade_bgr(12'hFFF, lvl)) begin failures++; $display("FAIL fade_in_rgb pulse %0d got %h exp %h", p, o, fade_bgr(12'hFFF, lvl)); end
        end
        checks++; if (vif.fade_busy !== 1'b1) begin failures++; $display("FAIL fade_in_mid_busy got %b exp 1", vif.fade_busy); end
        rst = 1'b1; #2;
        checks++; if (vif.fade_busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got %b exp 0", vif.fade_busy); end
        checks++; if (vif.rgb !== 12'h000) begin failures++; $display("FAIL rst_mid_rgb got %h exp 000", vif.rgb); end
        @(posedge clk); #1; rst = 1'b0;
        sample(10, 10, o, v);
        checks++; if (o !== 12'hFFF) begin failures++; $display("FAIL post_rst_rgb got %h exp fff", o); end
        checks++; if (vif.fade_busy !== 1'b0) begin failures++; $display("FAIL post_rst_busy got %b exp 0", vif.fade_busy); end
        pulse_frame(2'b00); pulse_frame(2'b00); pulse_frame(2'b00);
        sample(10, 10, o, v);
        checks++; if (o !== 12'hFFF) begin failures++; $display("FAIL post_rst_hold_rgb got %h exp fff", o); end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout reached before end of test sequence");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_priority();
        test_edges();
        test_random();
        test_fade_out();
        test_fade_in_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_sprite_compositor.md
# vga_sprite_compositor

Pipelined, parametrised pixel compositor for the VGA path. It overlays `NUM_SPRITES` fixed-size ROM sprites on a full-screen background ROM, with colour-key transparency and fixed index priority, and aligns its output to external synchronous ROM latency. A frame-synchronous fade-in/fade-out engine scales the final colour. Output is BGR-ordered 12-bit colour for the VGA driver.

## Interface

Parameters:
- `NUM_SPRITES`, 8: number of sprite channels.
- `SPRITE_W`, 30: sprite width in pixels.
- `SPRITE_H`, 30: sprite height in pixels.
- `SCREEN_W`, 640: background row pitch.
- `ROM_LAT`, 1: ROM read latency in cycles, ≥1.
- `KEY_COLOR`, 12'hF0F: transparent RGB value in sprite ROMs.
- `FRAMES_PER_STEP`, 2: frames per fade level step, ≥1.

Ports:
- `clk`, in, 1: pixel clock.
- `rst`, in, 1: reset. Asynchronous, active-high.
- `pix_x`, in, 10: current pixel column.
- `pix_y`, in, 9: current pixel row.
- `pix_valid`, in, 1: active-video qualifier for `pix_x`/`pix_y`.
- `frame_start`, in, 1: one-cycle pulse, once per frame, during blanking.
- `spr_en`, in, NUM_SPRITES: per-sprite enable.
- `spr_x`, in, NUM_SPRITES×10: sprite left edge.
- `spr_y`, in, NUM_SPRITES×9: sprite top edge.
- `spr_rom_addr`, out, NUM_SPRITES×clog2(SPRITE_W·SPRITE_H): per-sprite ROM address.
- `spr_rom_data`, in, NUM_SPRITES×12: per-sprite ROM data (RGB).
- `bg_rom_addr`, out, 19: background ROM address.
- `bg_rom_data`, in, 12: background ROM data (RGB).
- `fade_req`, in, 2: 00 none, 01 fade-out, 10 fade-in, 11 ignored.
- `fade_busy`, out, 1: high while fading.
- `rgb`, out, 12: composited colour, `{B,G,R}`.
- `rgb_valid`, out, 1: `pix_valid` delayed to match `rgb`.

## Operation

- **Stage A (combinational from pix inputs):**
  - Sprite i hits when `spr_en[i]`, `spr_x[i] ≤ pix_x < spr_x[i]+SPRITE_W` and `spr_y[i] ≤ pix_y < spr_y[i]+SPRITE_H`.
  - Compare in 11-bit (x) and 10-bit (y) arithmetic so edge sums never wrap.
  - Hit address = `(pix_x−spr_x)+(pix_y−spr_y)·SPRITE_W`. No hit gives address 0.
  - `bg_rom_addr = pix_x + pix_y·SCREEN_W`.
- **Delay line:** hit vector and `pix_valid` pass through a `ROM_LAT`-deep register chain to align with ROM data.
- **Stage B (select):**
  - Winner is the lowest index i with delayed hit and `spr_rom_data[i] ≠ KEY_COLOR`.
  - If there is no winner, use `bg_rom_data`.
  - Keyed pixels fall through to the next sprite index, then to background.
- **Fade:**
  - `level` is 5 bits, 0..16.
  - Each channel out = `(c·level)>>4`. Level 16 passes through, level 0 gives black.
  - Result is registered into `rgb` with channel order swapped to BGR.
- **Fade FSM states:** ON (level 16), FADE_OUT, OFF (level 0), FADE_IN.
  - ON + `fade_req=01` → FADE_OUT. OFF + `fade_req=10` → FADE_IN.
  - All other requests are ignored, including any request while fading.
  - While fading, a frame counter counts `frame_start` pulses. Each `FRAMES_PER_STEP`-th pulse changes `level` by 1 and clears the counter.
  - FADE_OUT reaching 0 → OFF. FADE_IN reaching 16 → ON.
  - `level` changes only on `frame_start` cycles, so a frame is never split between two levels.
- `fade_busy` = state ∈ {FADE_OUT, FADE_IN}.

## Timing

- **Latency:** `rgb`/`rgb_valid` correspond to `pix_x`/`pix_y` presented `ROM_LAT+1` cycles earlier.
- **Throughput:** one pixel per cycle, no stalls.
- **ROM addresses:** combinational. The ROM samples them on the same edge that loads stage 1 of the delay line.
- **Reset values:** `rgb` = 0, `rgb_valid` = 0, delay line cleared, state ON, `level` 16, frame counter 0, `fade_busy` 0.
- **Reset mid-fade:** returns to ON, level 16, on the next cycle after `rst` deasserts. There is no partial recovery.
- **Request and `frame_start` in the same cycle:** the request is accepted and the counter starts from that pulse. Counting begins with the next pulse, so the first step falls on the `FRAMES_PER_STEP`-th pulse after acceptance.
- **`pix_valid` low:** the pipeline still advances, but `rgb_valid` is low for those slots. `rgb` content is don't-care when `rgb_valid` is low.

## Test plan

- **Reset and background passthrough:** reset, no sprites, `bg_rom_data = 12'h123`, scan (0,0) → after 2 cycles (`ROM_LAT=1`), `rgb = 12'h321`, `rgb_valid = 1`. During `rst`, `rgb = 0`.
- **Sprite address and priority:** sprites 0 and 3 both at (100,50), sprite 0 data `12'h0F0`, sprite 3 data `12'hF00`; pixel (105,52) → `spr_rom_addr[0] = 65`, `rgb = 12'h0F0`.
- **Colour key:** as above with sprite 0 data = `KEY_COLOR` → `rgb = 12'h00F` (sprite 3). Sprite 3 also keyed → background.
- **Right-edge bounds:** `spr_x = 620`, pixel (639,y) → hit with column 19. Pixel (619,y) → no hit, address 0.
- **Fade-out:** `bg = 12'hFFF`, pulse `fade_req = 01` → `fade_busy` rises. After 2 `frame_start` pulses `rgb = 12'hEEE`. After 32 pulses `rgb = 0`, state OFF, `fade_busy = 0`. `fade_req = 01` in OFF → no change.
- **Fade-in and reset:** fade-in from OFF, assert `rst` at level 8 → `level = 16`, `fade_busy = 0`, and `rgb` equals unscaled data after release.
